// File: rtl/rv_multi_decode_stage.sv
// LANES-wide registered RV32I decode stage with a 2-entry skid buffer, illegal/HALT detection.
// Optional RV32M decode is enabled by defining RV_DECODE_M_EN.
module rv_multi_decode_stage #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES-1:0]      in_lane_mask,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [LANES-1:0]      out_lane_mask,
  output logic [LANES*6-1:0]    out_mnemonic,
  output logic [LANES*3-1:0]    out_unit,
  output logic [LANES*5-1:0]    out_rd,
  output logic [LANES*5-1:0]    out_rs1,
  output logic [LANES*5-1:0]    out_rs2,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES-1:0]      out_illegal,
  output logic                  out_halt,
  output logic                  halted
);

  if (XLEN != 32 || LANES < 1 || LANES > 4) begin : g_bad_param
    $error("rv_multi_decode_stage: XLEN must be 32 and LANES 1..4");
  end

  localparam logic [31:0] HALT_WORD = 32'h0001_0073;
  localparam logic [2:0] UNIT_ALU = 3'd0;
  localparam logic [2:0] UNIT_BRU = 3'd1;
  localparam logic [2:0] UNIT_MAU = 3'd2;

  typedef struct packed {
    logic            illegal;
    logic [5:0]      mn;
    logic [2:0]      unit;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
  } lane_t;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [LANES-1:0]       mask;
    logic                   halt;
    lane_t [LANES-1:0]      lane;
  } bundle_t;

  function automatic lane_t decode_lane(input logic [31:0] ins);
    lane_t       d;
    logic        ok;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_u = {ins[31:12], 12'b0};
    d  = '0;
    ok = 1'b1;
    case (ins[6:0])
      7'b0010011: begin
        d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.imm = imm_i; d.unit = UNIT_ALU;
        case (f3)
          3'b000: d.mn = 6'd0;
          3'b010: d.mn = 6'd1;
          3'b011: d.mn = 6'd2;
          3'b111: d.mn = 6'd3;
          3'b110: d.mn = 6'd4;
          3'b100: d.mn = 6'd5;
          3'b001: begin d.mn = 6'd6; ok = (f7 == 7'b0000000); end
          default: begin
            if (f7 == 7'b0000000)      d.mn = 6'd7;
            else if (f7 == 7'b0100000) d.mn = 6'd8;
            else                       ok = 1'b0;
          end
        endcase
      end
      7'b0110111: begin d.mn = 6'd9;  d.rd = ins[11:7]; d.imm = imm_u; d.unit = UNIT_ALU; end
      7'b0010111: begin d.mn = 6'd10; d.rd = ins[11:7]; d.imm = imm_u; d.unit = UNIT_ALU; end
      7'b0110011: begin
        d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.unit = UNIT_ALU;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: d.mn = 6'd11;
            3'b010: d.mn = 6'd13;
            3'b011: d.mn = 6'd14;
            3'b111: d.mn = 6'd15;
            3'b110: d.mn = 6'd16;
            3'b100: d.mn = 6'd17;
            3'b001: d.mn = 6'd18;
            default: d.mn = 6'd19;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.mn = 6'd12;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          d.mn = 6'd20;
        end else if (f7 == 7'b0000001) begin
`ifdef RV_DECODE_M_EN
          d.mn   = 6'd37 + {3'b000, f3};
          d.unit = 3'd3;
`else
          ok = 1'b0;
`endif
        end else begin
          ok = 1'b0;
        end
      end
      7'b1101111: begin d.mn = 6'd21; d.rd = ins[11:7]; d.imm = imm_j; d.unit = UNIT_BRU; end
      7'b1100111: begin
        d.mn = 6'd22; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.imm = imm_i; d.unit = UNIT_BRU;
        ok = (f3 == 3'b000);
      end
      7'b1100011: begin
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.imm = imm_b; d.unit = UNIT_BRU;
        case (f3)
          3'b000: d.mn = 6'd23;
          3'b001: d.mn = 6'd24;
          3'b100: d.mn = 6'd25;
          3'b110: d.mn = 6'd26;
          3'b101: d.mn = 6'd27;
          3'b111: d.mn = 6'd28;
          default: ok = 1'b0;
        endcase
      end
      7'b0000011: begin
        d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.imm = imm_i; d.unit = UNIT_MAU;
        case (f3)
          3'b010: d.mn = 6'd29;
          3'b001: d.mn = 6'd30;
          3'b101: d.mn = 6'd31;
          3'b100: d.mn = 6'd32;
          3'b000: d.mn = 6'd36;
          default: ok = 1'b0;
        endcase
      end
      7'b0100011: begin
        d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.imm = imm_s; d.unit = UNIT_MAU;
        case (f3)
          3'b010: d.mn = 6'd33;
          3'b001: d.mn = 6'd34;
          3'b000: d.mn = 6'd35;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  bundle_t in_bundle, main_q, skid_q, main_n, skid_n;
  logic    main_valid, skid_valid, main_valid_n, skid_valid_n, halted_n, stop;
  logic    in_fire, out_fire;

  // Lanes after the first masked-in HALT are dropped from the bundle entirely.
  always_comb begin
    in_bundle    = '0;
    in_bundle.pc = in_pc;
    stop         = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!stop && in_lane_mask[k]) begin
        in_bundle.mask[k] = 1'b1;
        if (in_instr[32*k +: 32] == HALT_WORD) begin
          in_bundle.halt = 1'b1;
          stop           = 1'b1;
        end else begin
          in_bundle.lane[k] = decode_lane(in_instr[32*k +: 32]);
        end
      end
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  always_comb begin
    main_n       = main_q;
    skid_n       = skid_q;
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    halted_n     = halted;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      if (out_fire) begin
        main_valid_n = skid_valid;
        skid_valid_n = 1'b0;
        if (skid_valid) main_n = skid_q;
      end
      if (in_fire) begin
        if (!main_valid_n) begin
          main_n       = in_bundle;
          main_valid_n = 1'b1;
        end else begin
          skid_n       = in_bundle;
          skid_valid_n = 1'b1;
        end
        halted_n = halted | in_bundle.halt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      halted     <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      halted     <= halted_n;
      in_ready   <= !skid_valid_n && !halted_n;
    end
  end

  assign out_valid     = main_valid;
  assign out_pc        = main_q.pc;
  assign out_lane_mask = main_q.mask;
  assign out_halt      = main_q.halt;

  always_comb begin
    out_mnemonic = '0;
    out_unit     = '0;
    out_rd       = '0;
    out_rs1      = '0;
    out_rs2      = '0;
    out_imm      = '0;
    out_illegal  = '0;
    for (int k = 0; k < LANES; k++) begin
      out_mnemonic[6*k +: 6]    = main_q.lane[k].mn;
      out_unit[3*k +: 3]        = main_q.lane[k].unit;
      out_rd[5*k +: 5]          = main_q.lane[k].rd;
      out_rs1[5*k +: 5]         = main_q.lane[k].rs1;
      out_rs2[5*k +: 5]         = main_q.lane[k].rs2;
      out_imm[XLEN*k +: XLEN]   = main_q.lane[k].imm;
      out_illegal[k]            = main_q.lane[k].illegal;
    end
  end

endmodule

// File: tb/tb_rv_multi_decode_stage.sv
// Directed self-checking bench for rv_multi_decode_stage (LANES=2); MUL expectations follow RV_DECODE_M_EN.
module tb_rv_multi_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_halt, halted;
  logic [63:0] in_instr, out_imm;
  logic [1:0]  in_lane_mask, out_lane_mask, out_illegal;
  logic [31:0] in_pc, out_pc;
  logic [11:0] out_mnemonic;
  logic [5:0]  out_unit;
  logic [9:0]  out_rd, out_rs1, out_rs2;

  int checks = 0;
  int errors = 0;
  logic [31:0] seen_pc[$];

  localparam logic [31:0] I_ADDI = 32'hFFB1_0093;
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;
  localparam logic [31:0] I_BEQ  = 32'hFE20_8CE3;
  localparam logic [31:0] I_HALT = 32'h0001_0073;
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;
  localparam logic [31:0] I_MUL  = 32'h0273_02B3;

  rv_multi_decode_stage #(.LANES(2), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_lane_mask(in_lane_mask), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_lane_mask(out_lane_mask), .out_mnemonic(out_mnemonic), .out_unit(out_unit),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_illegal(out_illegal), .out_halt(out_halt), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && out_valid && out_ready) seen_pc.push_back(out_pc);

  task automatic applyStimulus(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [1:0] m, input logic [31:0] pc);
    in_valid     = v;
    in_instr     = {i1, i0};
    in_lane_mask = m;
    in_pc        = pc;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_out_pc", out_pc, 0);
    checkOutput("rst_mnemonic", out_mnemonic, 0);
    reset = 1'b0;
    @(negedge clk);

    // ADDI + ADD bundle
    applyStimulus(1'b1, I_ADDI, I_ADD, 2'b11, 32'h100);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_pc", out_pc, 32'h100);
    checkOutput("t1_mask", out_lane_mask, 2'b11);
    checkOutput("t1_mn0", out_mnemonic[5:0], 0);
    checkOutput("t1_mn1", out_mnemonic[11:6], 11);
    checkOutput("t1_rd0", out_rd[4:0], 1);
    checkOutput("t1_rd1", out_rd[9:5], 3);
    checkOutput("t1_rs1_0", out_rs1[4:0], 2);
    checkOutput("t1_rs1_1", out_rs1[9:5], 1);
    checkOutput("t1_rs2_1", out_rs2[9:5], 2);
    checkOutput("t1_imm0", out_imm[31:0], 32'hFFFF_FFFB);
    checkOutput("t1_imm1", out_imm[63:32], 0);
    checkOutput("t1_unit", out_unit, 0);
    @(negedge clk);
    checkOutput("t1_drained", out_valid, 0);

    // BEQ on lane 0 only
    applyStimulus(1'b1, I_BEQ, I_ADD, 2'b01, 32'h200);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    checkOutput("beq_mn", out_mnemonic[5:0], 23);
    checkOutput("beq_unit", out_unit[2:0], 1);
    checkOutput("beq_rs1", out_rs1[4:0], 1);
    checkOutput("beq_rs2", out_rs2[4:0], 2);
    checkOutput("beq_rd", out_rd[4:0], 0);
    checkOutput("beq_imm", out_imm[31:0], 32'hFFFF_FFF8);
    checkOutput("beq_mask", out_lane_mask, 2'b01);
    checkOutput("beq_lane1_off", {out_mnemonic[11:6], out_rd[9:5], out_illegal[1]}, 0);
    @(negedge clk);

    // Illegal word on lane 0
    applyStimulus(1'b1, I_BAD, I_ADD, 2'b11, 32'h240);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    checkOutput("bad_illegal", out_illegal, 2'b01);
    checkOutput("bad_fields0", {out_mnemonic[5:0], out_unit[2:0], out_rd[4:0], out_rs1[4:0], out_rs2[4:0]}, 0);
    checkOutput("bad_imm0", out_imm[31:0], 0);
    checkOutput("bad_mask", out_lane_mask, 2'b11);
    checkOutput("bad_mn1", out_mnemonic[11:6], 11);
    @(negedge clk);

    // RV32M MUL x5,x6,x7
    applyStimulus(1'b1, I_MUL, 32'h0, 2'b01, 32'h280);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
`ifdef RV_DECODE_M_EN
    checkOutput("mul_illegal", out_illegal[0], 0);
    checkOutput("mul_mn", out_mnemonic[5:0], 37);
    checkOutput("mul_unit", out_unit[2:0], 3);
    checkOutput("mul_regs", {out_rd[4:0], out_rs1[4:0], out_rs2[4:0]}, {5'd5, 5'd6, 5'd7});
`else
    checkOutput("mul_illegal", out_illegal[0], 1);
    checkOutput("mul_mn", out_mnemonic[5:0], 0);
    checkOutput("mul_unit", out_unit[2:0], 0);
    checkOutput("mul_regs", {out_rd[4:0], out_rs1[4:0], out_rs2[4:0]}, 0);
`endif
    @(negedge clk);

    // Backpressure: 4 bundles, consumer stalled for 3 cycles
    seen_pc.delete();
    out_ready = 1'b0;
    applyStimulus(1'b1, I_ADD, I_ADD, 2'b11, 32'h1000);
    @(negedge clk);
    checkOutput("bp_ready_after1", in_ready, 1);
    applyStimulus(1'b1, I_ADD, I_ADD, 2'b11, 32'h1010);
    @(negedge clk);
    checkOutput("bp_ready_after2", in_ready, 0);
    applyStimulus(1'b1, I_ADD, I_ADD, 2'b11, 32'h1020);
    @(negedge clk);
    checkOutput("bp_ready_stall", in_ready, 0);
    checkOutput("bp_head_pc", out_pc, 32'h1000);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_ready_release", in_ready, 1);
    @(negedge clk);
    applyStimulus(1'b1, I_ADD, I_ADD, 2'b11, 32'h1030);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("bp_count", seen_pc.size(), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("bp_order%0d", k),
                  (k < seen_pc.size()) ? seen_pc[k] : 32'hDEAD_BEEF, 32'h1000 + 32'(16 * k));

    // Flush with two bundles buffered
    out_ready = 1'b0;
    applyStimulus(1'b1, I_ADD, I_ADD, 2'b11, 32'h2000);
    @(negedge clk);
    applyStimulus(1'b1, I_ADD, I_ADD, 2'b11, 32'h2010);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    checkOutput("fl_pre_valid", out_valid, 1);
    checkOutput("fl_pre_ready", in_ready, 0);
    seen_pc.delete();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("fl_valid", out_valid, 0);
    checkOutput("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("fl_nothing_emitted", seen_pc.size(), 0);

    // HALT on lane 0 suppresses lane 1 and stops the front end
    applyStimulus(1'b1, I_HALT, I_ADD, 2'b11, 32'h300);
    @(negedge clk);
    applyStimulus(1'b1, I_ADD, I_ADD, 2'b11, 32'h310);
    checkOutput("halt_valid", out_valid, 1);
    checkOutput("halt_flag", out_halt, 1);
    checkOutput("halt_mask", out_lane_mask, 2'b01);
    checkOutput("halt_illegal", out_illegal, 0);
    checkOutput("halt_fields", {out_mnemonic, out_rd, out_rs1, out_rs2}, 0);
    checkOutput("halt_imm", out_imm, 0);
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    checkOutput("halt_ready_stays", in_ready, 0);
    checkOutput("halt_no_new", out_valid, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("halt_rst_halted", halted, 0);
    checkOutput("halt_rst_ready", in_ready, 1);
    checkOutput("halt_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
